// File: rtl/stage_id_pkg.sv
//------------------------------------------------------------------------------
// Module      : stage_id_pkg
// Description : Opcodes, ALU class codes and control bundle for the ID stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stage_id_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ALUOP_W = 4;
  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = 4'b0010;

  localparam int WBI_REGWRITE = 1;
  localparam int WBI_ALURES   = 0;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic               isJump;
    logic               isNotConditional;
    logic               isEq;
    logic               memWrite;
    logic               memRead;
    logic [1:0]         wbi;
    logic               aluSrc;
    logic               regDst;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_NOP = '0;

  // Logical immediates take their operand unsigned; everything else is signed.
  function automatic logic isZeroExt(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_id_reg_file.sv
//------------------------------------------------------------------------------
// Module      : reg_file
// Description : 32x32 GPR file, two async read ports, one sync write port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file
  import stage_id_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (writeEn && (writeAddr != '0)) begin
      r_regs[writeAddr] <= writeData;
    end
  end

  // Register 0 is hard-wired so the read never depends on storage contents.
  assign readDataA = (readAddrA == '0) ? '0 : r_regs[readAddrA];
  assign readDataB = (readAddrB == '0) ? '0 : r_regs[readAddrB];

endmodule

`default_nettype wire

// File: rtl/stage_id.sv
//------------------------------------------------------------------------------
// Module      : stage_id
// Description : MIPS decode stage: control decode, GPR read, immediate extend.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stage_id
  import stage_id_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   instr,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [ADDR_W-1:0]   writeAddr,
  input  logic                regWrite,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                isJump,
  output logic                isNotConditional,
  output logic                isEq,
  output logic                memWrite,
  output logic                memRead,
  output logic [1:0]          wbi,
  output logic                aluSrc,
  output logic                regDst,
  output logic [DATA_W-1:0]   reg1,
  output logic [DATA_W-1:0]   reg2,
  output logic [DATA_W-1:0]   extendedInstr,
  output logic [ADDR_W-1:0]   regAddr1,
  output logic [ADDR_W-1:0]   regAddr2
);

  logic [5:0]        w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_readA;
  logic [DATA_W-1:0] w_readB;
  logic [DATA_W-1:0] w_extImm;
  ctrlBundle_t       w_ctrl;

  ctrlBundle_t       r_ctrl;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [DATA_W-1:0] r_ext;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;

  assign w_opcode = instr[31:26];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_imm    = instr[15:0];

  reg_file u_regFile (
    .clock     (clock),
    .reset     (reset),
    .readAddrA (w_rs),
    .readAddrB (w_rt),
    .readDataA (w_readA),
    .readDataB (w_readB),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .writeEn   (regWrite)
  );

  assign w_extImm = isZeroExt(w_opcode) ? {16'h0000, w_imm}
                                        : {{16{w_imm[15]}}, w_imm};

  always_comb begin
    w_ctrl = CTRL_NOP;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.aluOp                = ALU_RTYPE;
        w_ctrl.wbi[WBI_REGWRITE]    = 1'b1;
        w_ctrl.wbi[WBI_ALURES]      = 1'b1;
        w_ctrl.regDst               = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        // Immediate class code is the low opcode nibble; EX decodes it directly.
        w_ctrl.aluOp                = w_opcode[3:0];
        w_ctrl.wbi[WBI_REGWRITE]    = 1'b1;
        w_ctrl.wbi[WBI_ALURES]      = 1'b1;
        w_ctrl.aluSrc               = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        w_ctrl.aluOp                = ALU_ADD;
        w_ctrl.memRead              = 1'b1;
        w_ctrl.wbi[WBI_REGWRITE]    = 1'b1;
        w_ctrl.aluSrc               = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        w_ctrl.aluOp                = ALU_ADD;
        w_ctrl.memWrite             = 1'b1;
        w_ctrl.aluSrc               = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_ctrl.aluOp                = ALU_SUB;
        w_ctrl.isJump               = 1'b1;
        w_ctrl.isEq                 = (w_opcode == OP_BEQ);
      end
      OP_J: begin
        w_ctrl.aluOp                = ALU_SUB;
        w_ctrl.isJump               = 1'b1;
        w_ctrl.isNotConditional     = 1'b1;
      end
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  // Capture on the falling edge so a rising-edge WB write is already visible.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_ctrl  <= CTRL_NOP;
      r_reg1  <= '0;
      r_reg2  <= '0;
      r_ext   <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
    end else begin
      r_ctrl  <= w_ctrl;
      r_reg1  <= w_readA;
      r_reg2  <= w_readB;
      r_ext   <= w_extImm;
      r_addr1 <= w_rd;
      r_addr2 <= w_rt;
    end
  end

  assign aluOp            = r_ctrl.aluOp;
  assign isJump           = r_ctrl.isJump;
  assign isNotConditional = r_ctrl.isNotConditional;
  assign isEq             = r_ctrl.isEq;
  assign memWrite         = r_ctrl.memWrite;
  assign memRead          = r_ctrl.memRead;
  assign wbi              = r_ctrl.wbi;
  assign aluSrc           = r_ctrl.aluSrc;
  assign regDst           = r_ctrl.regDst;
  assign reg1             = r_reg1;
  assign reg2             = r_reg2;
  assign extendedInstr    = r_ext;
  assign regAddr1         = r_addr1;
  assign regAddr2         = r_addr2;

endmodule

`default_nettype wire

// File: tb/tb_stage_id.sv
//------------------------------------------------------------------------------
// Module      : tb_stage_id
// Description : Directed-vector bench for the decode stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stage_id;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] writeData;
  logic [4:0]  writeAddr;
  logic        regWrite;
  logic [3:0]  aluOp;
  logic        isJump;
  logic        isNotConditional;
  logic        isEq;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  wbi;
  logic        aluSrc;
  logic        regDst;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] extendedInstr;
  logic [4:0]  regAddr1;
  logic [4:0]  regAddr2;

  int nChecks = 0;
  int nErrors = 0;

  // ctrl layout: aluOp(4) isJump isNotCond isEq memWrite memRead wbi(2) aluSrc regDst
  localparam logic [12:0] C_RTYPE = 13'b0010_000_00_11_01;
  localparam logic [12:0] C_ANDI  = 13'b1100_000_00_11_10;
  localparam logic [12:0] C_ORI   = 13'b1101_000_00_11_10;
  localparam logic [12:0] C_ADDI  = 13'b1000_000_00_11_10;
  localparam logic [12:0] C_LOAD  = 13'b0000_000_01_10_10;
  localparam logic [12:0] C_STORE = 13'b0000_000_10_00_10;
  localparam logic [12:0] C_J     = 13'b0001_110_00_00_00;
  localparam logic [12:0] C_BEQ   = 13'b0001_101_00_00_00;
  localparam logic [12:0] C_BNE   = 13'b0001_100_00_00_00;
  localparam logic [12:0] C_NOP   = 13'b0;

  stage_id dut (
    .clock            (clock),
    .reset            (reset),
    .instr            (instr),
    .writeData        (writeData),
    .writeAddr        (writeAddr),
    .regWrite         (regWrite),
    .aluOp            (aluOp),
    .isJump           (isJump),
    .isNotConditional (isNotConditional),
    .isEq             (isEq),
    .memWrite         (memWrite),
    .memRead          (memRead),
    .wbi              (wbi),
    .aluSrc           (aluSrc),
    .regDst           (regDst),
    .reg1             (reg1),
    .reg2             (reg2),
    .extendedInstr    (extendedInstr),
    .regAddr1         (regAddr1),
    .regAddr2         (regAddr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive inputs, let one rising (write) and one falling (capture) edge pass,
  // then compare every output against the hand-computed values.
  task automatic doVec(input string tag, input logic rst, input logic [31:0] ins,
                       input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [12:0] expCtrl, input logic [31:0] expR1,
                       input logic [31:0] expR2, input logic [31:0] expExt,
                       input logic [4:0] expA1, input logic [4:0] expA2);
    logic [12:0] gotCtrl;
    reset     = rst;
    instr     = ins;
    regWrite  = wr;
    writeAddr = wa;
    writeData = wd;
    @(negedge clock);
    #1;
    gotCtrl = {aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi, aluSrc, regDst};
    checkEq({tag, ".ctrl"}, {19'b0, gotCtrl}, {19'b0, expCtrl});
    checkEq({tag, ".reg1"}, reg1, expR1);
    checkEq({tag, ".reg2"}, reg2, expR2);
    checkEq({tag, ".ext"}, extendedInstr, expExt);
    checkEq({tag, ".addr1"}, {27'b0, regAddr1}, {27'b0, expA1});
    checkEq({tag, ".addr2"}, {27'b0, regAddr2}, {27'b0, expA2});
  endtask

  initial begin
    reset = 1'b1; instr = '0; regWrite = 1'b0; writeAddr = '0; writeData = '0;
    @(negedge clock);
    doVec("rst0", 1'b1, 32'h8422_8000, 1'b0, 5'd0, 32'd0, C_NOP, 0, 0, 0, 5'd0, 5'd0);

    doVec("add",   1'b0, 32'h0000_0020, 1'b1, 5'd1,  32'd5,  C_RTYPE, 0,  0,  32'h0000_0020, 5'd0, 5'd0);
    doVec("andi",  1'b0, 32'h3022_0820, 1'b1, 5'd2,  32'd6,  C_ANDI,  5,  6,  32'h0000_0820, 5'd1, 5'd2);
    doVec("lh",    1'b0, 32'h8422_0020, 1'b1, 5'd11, 32'd13, C_LOAD,  5,  6,  32'h0000_0020, 5'd0, 5'd2);
    doVec("sb",    1'b0, 32'hA162_0820, 1'b1, 5'd12, 32'd14, C_STORE, 13, 6,  32'h0000_0820, 5'd1, 5'd2);
    doVec("j",     1'b0, 32'h096C_0020, 1'b0, 5'd0,  32'd0,  C_J,     13, 14, 32'h0000_0020, 5'd0, 5'd12);
    doVec("beq",   1'b0, 32'h1021_0820, 1'b0, 5'd0,  32'd0,  C_BEQ,   5,  5,  32'h0000_0820, 5'd1, 5'd1);
    doVec("bne",   1'b0, 32'h1422_0000, 1'b0, 5'd0,  32'd0,  C_BNE,   5,  6,  32'h0000_0000, 5'd0, 5'd2);
    doVec("oriR0", 1'b0, 32'h3401_8000, 1'b1, 5'd0,  32'hDEAD, C_ORI, 0,  5,  32'h0000_8000, 5'd16, 5'd1);
    doVec("addi",  1'b0, 32'h2001_8000, 1'b0, 5'd0,  32'd0,  C_ADDI,  0,  5,  32'hFFFF_8000, 5'd16, 5'd1);
    doVec("nop",   1'b0, 32'hFC22_1234, 1'b0, 5'd0,  32'd0,  C_NOP,   5,  6,  32'h0000_1234, 5'd2, 5'd2);

    doVec("rstMid", 1'b1, 32'h8422_8000, 1'b1, 5'd3, 32'd99, C_NOP,   0,  0,  0,             5'd0, 5'd0);

    doVec("lhNeg", 1'b0, 32'h8422_8000, 1'b0, 5'd0,  32'd0,  C_LOAD,  0,  0,  32'hFFFF_8000, 5'd16, 5'd2);
    doVec("jClr",  1'b0, 32'h096C_0020, 1'b0, 5'd0,  32'd0,  C_J,     0,  0,  32'h0000_0020, 5'd0, 5'd12);
    doVec("rClr",  1'b0, 32'h0060_1820, 1'b0, 5'd0,  32'd0,  C_RTYPE, 0,  0,  32'h0000_1820, 5'd3, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_id.md
# stage_id

Instruction-decode stage of the five-stage MIPS pipeline, sitting between IF and EX. Decodes the 32-bit instruction into EX/MEM/WB control signals, reads two operands from the integrated 32×32 register file, sign/zero-extends the immediate, and presents everything through an ID/EX output register. The register file write port is driven by the WB stage.

## Interface
- No parameters; widths fixed: data 32, register address 5, aluOp 4.
- One clock; reset is synchronous and active-high.
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction from IF/ID.
- writeData  in  32  WB write-back data.
- writeAddr  in  5  WB destination register.
- regWrite  in  1  WB write enable.
- aluOp  out  4  ALU operation class (see Operation).
- isJump  out  1  instruction is a branch or jump.
- isNotConditional  out  1  unconditional jump (J).
- isEq  out  1  branch condition: 1 = BEQ, 0 = BNE.
- memWrite  out  1  store.
- memRead  out  1  load.
- wbi  out  2  [1] = register write enable, [0] = 1 write ALU result, 0 write memory data.
- aluSrc  out  1  1 = second ALU operand is extendedInstr.
- regDst  out  1  1 = destination is rd (regAddr1), 0 = rt (regAddr2).
- reg1  out  32  GPR[rs] (instr[25:21]).
- reg2  out  32  GPR[rt] (instr[20:16]).
- extendedInstr  out  32  extended instr[15:0].
- regAddr1  out  5  rd = instr[15:11].
- regAddr2  out  5  rt = instr[20:16].

## Operation
- Opcode = instr[31:26]. Per-class outputs (aluOp, isJump, isNotConditional, isEq, memWrite, memRead, wbi, aluSrc, regDst):
- R-type 000000: 0010, 0,0,0, 0,0, 11, 0, 1. Funct is resolved in EX from extendedInstr[5:0].
- ALU immediates ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111: aluOp = opcode[3:0], branch/jump flags 0, memWrite 0, memRead 0, wbi 11, aluSrc 1, regDst 0.
- Loads LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101: 0000, 0,0,0, 0,1, 10, 1, 0.
- Stores SB 101000, SH 101001, SW 101011: 0000, 0,0,0, 1,0, 00, 1, 0.
- BEQ 000100 / BNE 000101: 0001, 1,0, isEq 1 / 0, 0,0, 00, 0, 0.
- J 000010: 0001, 1,1,0, 0,0, 00, 0, 0.
- Any other opcode: NOP, all control outputs 0. Operand, address and immediate fields are still passed through.
- Extension: zero-extend for ANDI/ORI/XORI; sign-extend for all other opcodes.
- Register file: 32×32. Register 0 always reads 0, and writes to it are ignored.

## Timing
- Register file write: on the rising edge of clock when regWrite=1.
- ID/EX output register: loads the decode of instr and the register reads on the falling edge of clock.
- Because the write happens half a cycle before the capture, a same-cycle write to rs/rt is seen by the read (write-before-read, no bypass needed).
- Latency: outputs reflect the instr present at the preceding falling edge and hold until the next falling edge.
- Reset: on the rising edge with reset=1, all GPRs are cleared to 0. On a falling edge with reset=1, all outputs are cleared to 0 (this is a NOP). WB writes are ignored while reset=1.

## Structure
- Shared package holds:
  - opcode constants;
  - aluOp encodings (ALU_ADD=0000, ALU_SUB=0001, ALU_RTYPE=0010, immediates = opcode[3:0]);
  - wbi bit positions.
- One sub-module, reg_file: two asynchronous read ports, one synchronous write port, synchronous reset.
- Control decode is a combinational case on the opcode, feeding the falling-edge output register.

## Test plan
- Write GPR1=5 with instr=0x00000020 (ADD) -> aluOp=2, wbi=11, regDst=1, aluSrc=0, regAddr1=0, regAddr2=0.
- Write GPR2=6, then ANDI 0x30220820 -> aluOp=1100, aluSrc=1, regDst=0, wbi=11, reg1=5, regAddr1=1, regAddr2=2, extendedInstr=0x00000820.
- Write GPR11=13, then LH 0x84220020 -> aluOp=0, memRead=1, wbi=10, aluSrc=1, reg1=5, reg2=6, regAddr1=0, regAddr2=2.
- Write GPR12=14, then SB 0xA1620820 -> memWrite=1, wbi[1]=0, aluSrc=1, reg1=13, reg2=6, regAddr1=1.
- J 0x096C0020 -> isJump=1, isNotConditional=1, aluOp=1, reg1=13, reg2=14, regAddr2=12. Then BEQ 0x10210820 -> isJump=1, isNotConditional=0, isEq=1, reg1=reg2=5.
- Reset mid-stream, plus a write to GPR0 -> all outputs 0; GPR0 and all cleared GPRs read 0. Also LH with immediate 0x8000 -> extendedInstr=0xFFFF8000.
